ddr_8to1_16chan_tx_framer: RTL

- Transmit-side word framer for the 16-lane DDR 8:1 LVDS link. Runs in the txclkdiv domain and drives the 128-bit parallel input of the OSERDES array.
- Generates the training pattern that the far-end receiver uses for bitslip/IDELAY alignment. Waits for that receiver to report training complete.
- Then streams user words from a small FIFO, inserting idle words whenever the FIFO is empty.

---
 rtl/ddr_8to1_16chan_tx_framer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ddr_8to1_16chan_tx_framer.sv
// Transmit word framer for the 16-lane DDR 8:1 LVDS link (txclkdiv domain).
// Sequences OSERDES reset, sends the receiver training pattern until the far end
// reports alignment, then streams user words from a small FIFO with idle fill.
// Optional build macro TX_IDLE_PRBS_EN replaces the DATA-state idle fill with PRBS7.
module ddr_8to1_16chan_tx_framer #(
  parameter int unsigned NCHAN                = 16,
  parameter int unsigned WORD_W               = 8,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN  = 8'h80,
  parameter logic [WORD_W-1:0] IDLE_WORD      = 8'h00,
  parameter int unsigned TRAIN_MIN            = 64,
  parameter int unsigned TRAIN_TIMEOUT        = 4096,
  parameter int unsigned FIFO_DEPTH           = 4,
  parameter int unsigned OSR_HOLD             = 4
) (
  input  logic                            txclkdiv,
  input  logic                            txrst_n,
  input  logic                            train_req,
  input  logic                            rx_training_done,
  input  logic [NCHAN*WORD_W-1:0]         s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [NCHAN*WORD_W-1:0]         data_to_oserdes,
  output logic                            oserdes_rst,
  output logic                            training_active,
  output logic                            link_up,
  output logic                            train_timeout,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned DW = NCHAN * WORD_W;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(TRAIN_TIMEOUT) + 1;
  localparam int unsigned HW = $clog2(OSR_HOLD) + 1;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_TRAIN = 2'd2;
  localparam logic [1:0] ST_DATA  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [HW-1:0]       hold_q;
  logic [CW-1:0]       cnt_q;
  logic                timeout_q;
  logic [DW-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic                push, pop, flush;
  logic [DW-1:0]       fill_word;
  logic [DW-1:0]       data_d;
  logic [DW-1:0]       data_q;

  // Next-state decode; reset itself is applied in the state register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:   if (hold_q == HW'(OSR_HOLD - 1)) state_d = ST_IDLE;
      ST_IDLE:  if (train_req) state_d = ST_TRAIN;
      ST_TRAIN: begin
        // Successful alignment takes precedence over a coincident timeout.
        if ((cnt_q >= CW'(TRAIN_MIN - 1)) && rx_training_done) state_d = ST_DATA;
        else if (cnt_q == CW'(TRAIN_TIMEOUT - 1))             state_d = ST_IDLE;
      end
      ST_DATA:  if (train_req) state_d = ST_TRAIN;
      default:  state_d = ST_RST;
    endcase
  end

  assign oserdes_rst     = (state_q == ST_RST);
  assign training_active = (state_q == ST_TRAIN);
  assign link_up         = (state_q == ST_DATA);
  assign train_timeout   = timeout_q;
  assign fifo_level      = level_q;
  // Occupancy-based only; a same-cycle pop is deliberately not anticipated.
  assign s_ready         = (state_q == ST_DATA) && (level_q < LW'(FIFO_DEPTH));

  // Words accepted in the cycle that leaves DATA are dropped with the flush.
  assign push  = s_valid && s_ready && (state_d == ST_DATA);
  assign pop   = (state_q == ST_DATA) && (state_d == ST_DATA) && (level_q != '0);
  assign flush = (state_q == ST_DATA) && (state_d != ST_DATA);

  // State, reset-hold counter, training counter and sticky timeout flag.
  always_ff @(posedge txclkdiv) begin
    if (!txrst_n) begin
      state_q   <= ST_RST;
      hold_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RST) hold_q <= hold_q + 1'b1;
      if (state_d == ST_TRAIN && state_q != ST_TRAIN) begin
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else if (state_q == ST_TRAIN) begin
        cnt_q <= cnt_q + 1'b1;
        if (state_d == ST_IDLE) timeout_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge txclkdiv) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge txclkdiv) begin
    if (!txrst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

`ifdef TX_IDLE_PRBS_EN
  logic [6:0]        lfsr_q, lfsr_cur, lfsr_nxt;
  logic [WORD_W-1:0] prbs_byte;

  // PRBS7 (x^7+x^6+1), WORD_W steps per idle cycle; reseeded on DATA entry.
  always_comb begin
    lfsr_cur  = (state_q == ST_DATA) ? lfsr_q : 7'h7F;
    lfsr_nxt  = lfsr_cur;
    prbs_byte = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      prbs_byte[i] = lfsr_nxt[6] ^ lfsr_nxt[5];
      lfsr_nxt     = {lfsr_nxt[5:0], prbs_byte[i]};
    end
  end

  assign fill_word = {NCHAN{prbs_byte}};

  // LFSR advances only on idle-fill cycles in DATA.
  always_ff @(posedge txclkdiv) begin
    if (!txrst_n)                          lfsr_q <= 7'h7F;
    else if (state_d == ST_DATA && !pop)   lfsr_q <= lfsr_nxt;
  end
`else
  assign fill_word = {NCHAN{IDLE_WORD}};
`endif

  // Output mux keyed on the state being entered, so the word matches the new state.
  always_comb begin
    data_d = '0;
    case (state_d)
      ST_RST:   data_d = '0;
      ST_IDLE:  data_d = {NCHAN{IDLE_WORD}};
      ST_TRAIN: data_d = {NCHAN{TRAIN_PATTERN}};
      ST_DATA:  data_d = pop ? mem[rd_ptr_q] : fill_word;
      default:  data_d = '0;
    endcase
  end

  // Registered parallel word to the OSERDES array.
  always_ff @(posedge txclkdiv) begin
    if (!txrst_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_to_oserdes = data_q;

endmodule
